// File: rtl/conv_layer_mem.sv
// rtl/conv_layer_mem.sv - CONV layer-memory responder: five result banks, registered reads, write progress and error flags
// Optional build macro CONV_MEM_FWD_EN selects write-first collisions; read-first otherwise.
module conv_layer_mem #(
   parameter int DW = 20,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    csel,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          clr,
   output logic [4:0]    bank_full,
   output logic          addr_err
);

   function automatic logic [12:0] depth_of(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1: depth_of = 13'd4096;
         3'd2, 3'd3: depth_of = 13'd1024;
         3'd4:       depth_of = 13'd2048;
         default:    depth_of = 13'd0;
      endcase
   endfunction

   logic [DW-1:0] mem0 [4096];
   logic [DW-1:0] mem1 [4096];
   logic [DW-1:0] mem2 [1024];
   logic [DW-1:0] mem3 [1024];
   logic [DW-1:0] mem4 [2048];

   logic [DW-1:0] cdata_rd_q, cdata_rd_d;
   logic [12:0]   cnt_q [5];
   logic [12:0]   cnt_d [5];
   logic          addr_err_q, addr_err_d;

   logic          sel_ok;
   logic [2:0]    idx;
   logic          rd_acc_ok, wr_acc_ok, rd_ok, wr_ok, fwd;
   logic [DW-1:0] rd_mem;

   always_comb begin
      sel_ok    = (csel >= 3'd1) && (csel <= 3'd5);
      idx       = csel - 3'd1;
      rd_acc_ok = sel_ok && (32'(caddr_rd) < 32'(depth_of(idx)));
      wr_acc_ok = sel_ok && (32'(caddr_wr) < 32'(depth_of(idx)));
      rd_ok     = crd && rd_acc_ok;
      wr_ok     = cwr && wr_acc_ok;
`ifdef CONV_MEM_FWD_EN
      fwd       = wr_ok && (caddr_wr == caddr_rd);
`else
      fwd       = 1'b0;
`endif
   end

   always_comb begin
      rd_mem = '0;
      case (csel)
         3'd1:    rd_mem = mem0[caddr_rd[11:0]];
         3'd2:    rd_mem = mem1[caddr_rd[11:0]];
         3'd3:    rd_mem = mem2[caddr_rd[9:0]];
         3'd4:    rd_mem = mem3[caddr_rd[9:0]];
         3'd5:    rd_mem = mem4[caddr_rd[10:0]];
         default: rd_mem = '0;
      endcase
   end

   always_comb begin
      cdata_rd_d = cdata_rd_q;
      if (crd) begin
         if (!rd_ok)   cdata_rd_d = '0;
         else if (fwd) cdata_rd_d = cdata_wr;
         else          cdata_rd_d = rd_mem;
      end
   end

   // Counters count every valid write and stop at the bank depth; clr overrides.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr)
            cnt_d[i] = '0;
         else if (wr_ok && (idx == 3'(i)) && (cnt_q[i] != depth_of(3'(i))))
            cnt_d[i] = cnt_q[i] + 13'd1;
      end
      addr_err_d = clr ? 1'b0
                 : (addr_err_q | (crd && !rd_acc_ok) | (cwr && !wr_acc_ok));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdata_rd_q <= '0;
         addr_err_q <= 1'b0;
         for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      end else begin
         cdata_rd_q <= cdata_rd_d;
         addr_err_q <= addr_err_d;
         for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         case (csel)
            3'd1:    mem0[caddr_wr[11:0]] <= cdata_wr;
            3'd2:    mem1[caddr_wr[11:0]] <= cdata_wr;
            3'd3:    mem2[caddr_wr[9:0]]  <= cdata_wr;
            3'd4:    mem3[caddr_wr[9:0]]  <= cdata_wr;
            3'd5:    mem4[caddr_wr[10:0]] <= cdata_wr;
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 5; i++) bank_full[i] = (cnt_q[i] == depth_of(3'(i)));
   end

   assign cdata_rd = cdata_rd_q;
   assign addr_err = addr_err_q;

endmodule

// File: doc/conv_layer_mem.md
# conv_layer_mem

Synthesizable responder for the CONV layer-memory port. It holds the five result banks (layer-0 kernel 0/1, layer-1 kernel 0/1, layer-2 flatten) behind the shared csel/crd/cwr interface. It accepts writes and serves reads with one-cycle registered latency. It also tracks per-bank write progress and address errors, so CONV can be integrated on-chip without the behavioural memory model.

## Interface
Parameters:
- DW, 20: data width of cdata_wr / cdata_rd.
- AW, 12: address width of caddr_rd / caddr_wr.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- csel  in  3  bank select, shared by the read and write paths.
- crd  in  1  read request.
- caddr_rd  in  AW  read address.
- cdata_rd  out  DW  registered read data.
- cwr  in  1  write request.
- caddr_wr  in  AW  write address.
- cdata_wr  in  DW  write data.
- clr  in  1  synchronous clear of counters and flags; memory contents are kept.
- bank_full  out  5  per-bank flag, bit i means bank i+1 has received depth writes.
- addr_err  out  1  sticky flag for an invalid csel or an out-of-range address on any access.

## Operation
- csel decode:
  - 3'b001: L0 bank 0, depth 4096.
  - 3'b010: L0 bank 1, depth 4096.
  - 3'b011: L1 bank 0, depth 1024.
  - 3'b100: L1 bank 1, depth 1024.
  - 3'b101: L2 bank, depth 2048.
  - 3'b000, 3'b110, 3'b111: invalid.
- Access is valid when csel is valid and address < bank depth.
- Write: when cwr=1 and the access is valid, mem[csel][caddr_wr] <= cdata_wr at the rising edge.
  - The bank write counter (13-bit) increments and saturates at depth.
  - bank_full[i] asserts when counter == depth.
  - Counting is per write, not per unique address; rewriting an address still counts.
- Read: when crd=1 and the access is valid, cdata_rd <= mem[csel][caddr_rd].
  - Invalid read: cdata_rd <= 0.
  - crd=0: cdata_rd holds its previous value.
- addr_err sets on any crd or cwr with an invalid access; it stays set until clr or reset.
- An invalid write never modifies memory or counters.
- Simultaneous crd and cwr to the same bank and address: behaviour depends on the configuration macro (see Configuration).
- Simultaneous crd and cwr to different addresses are both serviced in the same cycle.
- clr=1: all counters, bank_full and addr_err go to 0.
  - If cwr is also asserted that cycle, clr wins for counters; the memory write still occurs.
- Memory arrays are not reset; their contents are undefined until written.

## Timing
- Reset values: cdata_rd=0, bank_full=5'b0, addr_err=0; all counters 0.
- Reset is asynchronous assert; deassertion is synchronized by the integrator.
- Reset mid-operation aborts any in-flight read (cdata_rd goes to 0) and clears all counters. Memory is untouched.
- Read latency is 1 cycle: crd sampled at edge N drives cdata_rd after edge N, stable for CONV to sample at edge N+1.
- Write latency is 0 cycles: data written at edge N is readable by a crd sampled at edge N+1.
- bank_full and addr_err update at the same edge as the triggering access and are visible after it.
- No backpressure: every request is accepted every cycle, with unbounded back-to-back throughput.

## Configuration
- CONV_MEM_FWD_EN defined: write-first. A same-cycle crd and cwr with matching csel and address returns cdata_wr on cdata_rd.
- CONV_MEM_FWD_EN undefined: read-first. cdata_rd returns the pre-write memory content.
- All other behaviour is identical in both builds.

## Test plan
- Reset check: hold reset=0 with crd=1 at random addresses -> cdata_rd=0, bank_full=0, addr_err=0 throughout.
- Per-bank round trip:
  - Stimulus: write caddr_wr=0x005, cdata_wr=0x12345 with csel=3'b011; then crd at 0x005, same csel.
  - Response: cdata_rd=0x12345 one cycle after the read. The same address read in bank 3'b100 is unaffected.
- Full flag: write all 1024 addresses of csel=3'b100.
  - bank_full[3] rises after the 1024th write edge and stays set through extra writes.
  - Then clr=1 for one cycle -> bank_full=0.
- Range and select errors:
  - cwr to csel=3'b011, addr 0x400 -> memory unchanged, addr_err=1.
  - clr, then crd with csel=3'b110 -> cdata_rd=0, addr_err=1.
- Same-cycle collision: mem[1][0x010]=0xAAAAA, then crd and cwr together to csel=3'b001, addr 0x010 with data 0x55555.
  - With CONV_MEM_FWD_EN: cdata_rd=0x55555.
  - Without CONV_MEM_FWD_EN: cdata_rd=0xAAAAA, and a following read gives 0x55555.
- Mid-run reset: pulse reset low during a burst of L2 writes at address 1000.
  - bank_full=0 and counters restart from 0.
  - Previously written L2 data is still readable.
